// File: rtl/spi_and4_target.sv
`timescale 1ns/1ps
// SPI mode-0 target for the 4-bit AND operand link: byte {a,b} in on MOSI, status {y, cnt[3:0]} out on MISO.
// Latency: pin edges seen SYNC_STAGES+1 clk later; results/frame_valid one cycle after the 8th sclk rise is detected.
// Backpressure: none; the initiator must respect minimum sclk high/low and cs_n setup/hold times in clk periods.
module spi_and4_target #(
   parameter int SYNC_STAGES = 2   // must be >= 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic [3:0] a_out,
   output logic [3:0] b_out,
   output logic [3:0] y_out,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [7:0] frame_cnt
);

   localparam logic [1:0] ST_LOCKOUT = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_ACTIVE  = 2'd2;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_hist_q, cs_hist_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [1:0] state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       reload_q, reload_d;
   logic       miso_q, miso_d;
   logic [3:0] a_q, a_d, b_q, b_d, y_q, y_d;
   logic [7:0] cnt_q, cnt_d;
   logic       valid_q, valid_d, err_q, err_d;

   logic [7:0] rx_next;
   logic [3:0] y_next;
   logic [7:0] cnt_next;

   // Synchronizers plus one history flop for edge detection. cs_n resets low so
   // LOCKOUT only exits once a genuine high has propagated through the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign cs_rise   = cs_s & ~cs_hist_q;
   assign cs_fall   = ~cs_s & cs_hist_q;

   assign rx_next  = {rx_q[6:0], mosi_s};
   assign y_next   = rx_next[7:4] & rx_next[3:0];
   assign cnt_next = cnt_q + 8'd1;

   // Frame FSM: cs_n edges take priority over sclk edges seen in the same cycle.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      reload_d = reload_q;
      miso_d   = miso_q;
      a_d      = a_q;
      b_d      = b_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_LOCKOUT: begin
            miso_d = 1'b0;
            if (cs_s) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d  = ST_ACTIVE;
               bitcnt_d = 3'd0;
               tx_d     = {y_q, cnt_q[3:0]};
               reload_d = 1'b0;
               miso_d   = y_q[3];
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               // Partial byte is dropped; only the error pulse reports it.
               state_d  = ST_IDLE;
               miso_d   = 1'b0;
               reload_d = 1'b0;
               err_d    = (bitcnt_q != 3'd0);
            end else if (sclk_rise) begin
               rx_d     = rx_next;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  a_d      = rx_next[7:4];
                  b_d      = rx_next[3:0];
                  y_d      = y_next;
                  cnt_d    = cnt_next;
                  valid_d  = 1'b1;
                  tx_d     = {y_next, cnt_next[3:0]};
                  reload_d = 1'b1;
               end
            end else if (sclk_fall) begin
               // After a reload the MSB is already in place: present it unshifted.
               if (reload_q) begin
                  reload_d = 1'b0;
                  miso_d   = tx_q[7];
               end else begin
                  tx_d   = {tx_q[6:0], 1'b0};
                  miso_d = tx_q[6];
               end
            end
         end
         default: begin
            state_d = ST_LOCKOUT;
            miso_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LOCKOUT;
         bitcnt_q <= 3'd0;
         rx_q     <= 8'h00;
         tx_q     <= 8'h00;
         reload_q <= 1'b0;
         miso_q   <= 1'b0;
         a_q      <= 4'h0;
         b_q      <= 4'h0;
         y_q      <= 4'h0;
         cnt_q    <= 8'h00;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         reload_q <= reload_d;
         miso_q   <= miso_d;
         a_q      <= a_d;
         b_q      <= b_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign miso        = miso_q;
   assign a_out       = a_q;
   assign b_out       = b_q;
   assign y_out       = y_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_spi_and4_target.sv
`timescale 1ns/1ps
// Directed bench for spi_and4_target: bit-banged SPI initiator with hand-computed expectations.
// Latency: each SPI half-period is H clk cycles, comfortably above the synchronizer delay.
// Backpressure: none; frame_valid/frame_err pulses are counted on the falling clk edge.
module tb_spi_and4_target;
   localparam int H = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk  = 1'b0;
   logic       cs_n  = 1'b1;
   logic       mosi  = 1'b0;
   logic       miso;
   logic [3:0] a_out, b_out, y_out;
   logic       frame_valid, frame_err;
   logic [7:0] frame_cnt;

   int checks  = 0;
   int errors  = 0;
   int nvalid  = 0;
   int nerr    = 0;
   int overlap = 0;

   always #5 clk = ~clk;

   spi_and4_target #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .a_out(a_out), .b_out(b_out), .y_out(y_out),
      .frame_valid(frame_valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_valid) nvalid++;
      if (frame_err) nerr++;
      if (frame_valid && frame_err) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift the top nbits of d out MSB first; capture MISO just before each rising sclk.
   task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = d[7-i];
         wait_clk(H);
         r[7-i] = miso;
         sclk = 1'b1;
         wait_clk(H);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] d, output logic [7:0] r);
      cs_n = 1'b0;
      wait_clk(H);
      xfer(d, 8, r);
      wait_clk(H);
      cs_n = 1'b1;
      wait_clk(2*H);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(4);
   endtask

   initial begin
      logic [7:0] r, r1, r2;
      int v0, e0;

      // Reset with cs_n high
      wait_clk(3);
      chk("rst_miso", miso, 0);
      chk("rst_valid", frame_valid, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_a", a_out, 0);
      chk("rst_b", b_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      wait_clk(4);

      // Single frame 0x4C, then 0x00 reads back {y=4, cnt=1}
      v0 = nvalid;
      frame(8'h4C, r);
      chk("f1_miso", r, 8'h00);
      chk("f1_a", a_out, 4'h4);
      chk("f1_b", b_out, 4'hC);
      chk("f1_y", y_out, 4'h4);
      chk("f1_cnt", frame_cnt, 8'h01);
      chk("f1_nvalid", nvalid - v0, 1);
      frame(8'h00, r);
      chk("f2_miso", r, 8'h41);

      // Back-to-back bytes under one cs_n
      do_reset();
      v0 = nvalid;
      cs_n = 1'b0;
      wait_clk(H);
      xfer(8'hFF, 8, r1);
      xfer(8'h3A, 8, r2);
      wait_clk(H);
      cs_n = 1'b1;
      wait_clk(2*H);
      chk("b2b_miso0", r1, 8'h00);
      chk("b2b_miso1", r2, 8'hF1);
      chk("b2b_nvalid", nvalid - v0, 2);
      chk("b2b_y", y_out, 4'h2);
      chk("b2b_cnt", frame_cnt, 8'h02);

      // Abort after 5 bits
      v0 = nvalid;
      e0 = nerr;
      cs_n = 1'b0;
      wait_clk(H);
      xfer(8'hA5, 5, r);
      wait_clk(H);
      cs_n = 1'b1;
      wait_clk(2*H);
      chk("abort_nerr", nerr - e0, 1);
      chk("abort_nvalid", nvalid - v0, 0);
      chk("abort_a", a_out, 4'h3);
      chk("abort_b", b_out, 4'hA);
      chk("abort_y", y_out, 4'h2);
      chk("abort_cnt", frame_cnt, 8'h02);
      frame(8'h96, r);
      chk("post_abort_y", y_out, 4'h0);
      chk("post_abort_cnt", frame_cnt, 8'h03);
      chk("post_abort_miso", r, 8'h22);

      // Reset mid-frame with cs_n held low
      cs_n = 1'b0;
      wait_clk(H);
      xfer(8'hFF, 3, r);
      rst_n = 1'b0;
      #1;
      chk("midrst_cnt", frame_cnt, 8'h00);
      chk("midrst_y", y_out, 4'h0);
      wait_clk(2);
      rst_n = 1'b1;
      v0 = nvalid;
      e0 = nerr;
      xfer(8'hFF, 5, r);
      wait_clk(H);
      chk("lock_miso", r, 8'h00);
      cs_n = 1'b1;
      wait_clk(2*H);
      chk("lock_nvalid", nvalid - v0, 0);
      chk("lock_nerr", nerr - e0, 0);
      chk("lock_cnt", frame_cnt, 8'h00);
      frame(8'hF7, r);
      chk("after_lock_y", y_out, 4'h7);
      chk("after_lock_cnt", frame_cnt, 8'h01);

      // 256 frames wrap the frame counter
      do_reset();
      v0 = nvalid;
      for (int i = 0; i < 256; i++) frame(8'h11, r);
      chk("wrap_cnt", frame_cnt, 8'h00);
      chk("wrap_nvalid", nvalid - v0, 256);
      chk("wrap_y", y_out, 4'h1);
      frame(8'h11, r);
      chk("wrap_miso_lo", r[3:0], 4'h0);
      chk("wrap_miso", r, 8'h10);
      chk("wrap_cnt_next", frame_cnt, 8'h01);

      chk("pulse_overlap", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
